// File: rtl/bist_pkg.sv
// Shared BIST definitions: controller state encoding and the default run
// length / golden signature used by the datapath and the bench.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } bist_state_e;

  localparam int unsigned BIST_N_PATTERNS = 1000;
  localparam int unsigned BIST_CNT_W      = 10;
  localparam int unsigned BIST_SIG_W      = 16;
  localparam logic [BIST_SIG_W-1:0] BIST_GOLDEN_SIG = 16'h0000;

endpackage

// File: rtl/bist_pattern_cnt.sv
// Pattern/flush counter: clear wins over enable; at_tc flags the terminal
// count so the sequencer can leave RUN or FLUSH on that cycle.
module bist_pattern_cnt #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc,
  output logic             at_tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign at_tc = (cnt == tc);

endmodule

// File: rtl/bist_ctrl.sv
// BIST sequencer: loads/steps the LFSR, clears/enables the MISR through a
// LAT-deep delay line, then compares the final signature against GOLDEN_SIG.
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned     N_PATTERNS = BIST_N_PATTERNS,
  parameter int unsigned     CNT_W      = BIST_CNT_W,
  parameter int unsigned     LAT        = 1,
  parameter int unsigned     SIG_W      = BIST_SIG_W,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = BIST_GOLDEN_SIG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIG_W-1:0] sig_in,
  output logic             lfsr_load,
  output logic             lfsr_en,
  output logic             misr_clr,
  output logic             misr_en,
  output logic             test_mode,
  output logic             running,
  output logic             bist_end,
  output logic             bist_pass
);

  localparam logic [CNT_W-1:0] RUN_TC   = CNT_W'(N_PATTERNS - 1);
  localparam logic [CNT_W-1:0] FLUSH_TC = (LAT == 0) ? '0 : CNT_W'(LAT - 1);

  bist_state_e      state;
  logic             start_q;
  logic             trig;
  logic             at_tc;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] tc;

  // start_q resets high so a start held through reset release is not an edge
  assign trig = start & ~start_q;

  // One counter serves both phases; it restarts on entry to RUN and to FLUSH
  assign tc      = (state == S_FLUSH) ? FLUSH_TC : RUN_TC;
  assign cnt_clr = (state == S_INIT) || ((state == S_RUN) && at_tc);
  assign cnt_en  = (state == S_RUN) || (state == S_FLUSH);

  bist_pattern_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (tc),
    .at_tc (at_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      start_q   <= 1'b1;
      lfsr_load <= 1'b0;
      lfsr_en   <= 1'b0;
      misr_clr  <= 1'b0;
      test_mode <= 1'b0;
      running   <= 1'b0;
      bist_end  <= 1'b0;
      bist_pass <= 1'b0;
    end else begin
      start_q   <= start;
      lfsr_load <= 1'b0;
      misr_clr  <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (trig) begin
            state     <= S_INIT;
            lfsr_load <= 1'b1;
            misr_clr  <= 1'b1;
            test_mode <= 1'b1;
            running   <= 1'b1;
            bist_end  <= 1'b0;
            bist_pass <= 1'b0;
          end
        end
        S_INIT: begin
          state   <= S_RUN;
          lfsr_en <= 1'b1;
        end
        S_RUN: begin
          if (at_tc) begin
            lfsr_en <= 1'b0;
            state   <= (LAT == 0) ? S_CHECK : S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (at_tc) state <= S_CHECK;
        end
        S_CHECK: begin
          state     <= S_DONE;
          bist_pass <= (sig_in == GOLDEN_SIG);
          bist_end  <= 1'b1;
          running   <= 1'b0;
          test_mode <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          lfsr_en   <= 1'b0;
          test_mode <= 1'b0;
          running   <= 1'b0;
          bist_end  <= 1'b0;
          bist_pass <= 1'b0;
        end
      endcase
    end
  end

  // misr_en tracks lfsr_en through the CUT+capture latency
  generate
    if (LAT == 0) begin : g_no_dly
      assign misr_en = lfsr_en;
    end else begin : g_dly
      logic [LAT:1] vld_pipe;
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[1] <= lfsr_en;
          for (int i = 2; i <= LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end
      assign misr_en = vld_pipe[LAT];
    end
  endgenerate

endmodule

// File: tb/tb_bist_ctrl.sv
// Directed bench: one controller with LAT=2 and one with LAT=0, 8 patterns,
// golden signature 16'hBEEF; run traces are tallied and checked per run.
module tb_bist_ctrl;
  import bist_pkg::*;

  localparam logic [15:0] GS = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b1;
  logic        start_z = 1'b1;
  logic [15:0] sig_in = GS;
  // bit map: 7 load, 6 lfsr_en, 5 misr_clr, 4 misr_en, 3 test_mode, 2 running, 1 end, 0 pass
  logic [7:0]  oa;
  logic [7:0]  oz;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bist_ctrl #(
    .N_PATTERNS (8), .CNT_W (4), .LAT (2), .SIG_W (16), .GOLDEN_SIG (GS)
  ) u_dut_a (
    .clk (clk), .rst (rst), .start (start_a), .sig_in (sig_in),
    .lfsr_load (oa[7]), .lfsr_en (oa[6]), .misr_clr (oa[5]), .misr_en (oa[4]),
    .test_mode (oa[3]), .running (oa[2]), .bist_end (oa[1]), .bist_pass (oa[0])
  );

  bist_ctrl #(
    .N_PATTERNS (8), .CNT_W (4), .LAT (0), .SIG_W (16), .GOLDEN_SIG (GS)
  ) u_dut_z (
    .clk (clk), .rst (rst), .start (start_z), .sig_in (sig_in),
    .lfsr_load (oz[7]), .lfsr_en (oz[6]), .misr_clr (oz[5]), .misr_en (oz[4]),
    .test_mode (oz[3]), .running (oz[2]), .bist_end (oz[1]), .bist_pass (oz[0])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs(input bit sel);
    return sel ? oz : oa;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_z = v;
    else     start_a = v;
  endtask

  // Trigger one run on the selected controller and watch 30 cycles.
  // p1/p2: cycles whose following edge sees an extra start pulse (0 = none).
  task automatic run(input bit sel, input logic [15:0] sig, input bit exp_pass,
                     input int p1, input int p2, input string tag);
    int n_load, n_clr, n_len, n_men, t_run, t_len, t_men, t_end, n_both, n_rise;
    logic [7:0] o;
    logic prev_end;
    n_load = 0; n_clr = 0; n_len = 0; n_men = 0; n_both = 0; n_rise = 0;
    t_run = -1; t_len = -1; t_men = -1; t_end = -1;
    sig_in = sig;
    set_start(sel, 1'b0);
    @(negedge clk);
    prev_end = outs(sel)[1];
    set_start(sel, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      set_start(sel, (c == p1) || (c == p2));
      o = outs(sel);
      if (c == 1) begin
        chk({tag, "_init_end"},  o[1], 1'b0);
        chk({tag, "_init_pass"}, o[0], 1'b0);
        chk({tag, "_init_tm"},   o[3], 1'b1);
      end
      if (o[7]) n_load++;
      if (o[5]) n_clr++;
      if (o[6]) begin n_len++; if (t_len < 0) t_len = c; end
      if (o[4]) begin n_men++; if (t_men < 0) t_men = c; end
      if (o[2] && t_run < 0) t_run = c;
      if (o[1] && t_end < 0) t_end = c;
      if (o[1] && o[2]) n_both++;
      if (o[1] && !prev_end) n_rise++;
      prev_end = o[1];
    end
    o = outs(sel);
    chk({tag, "_run_rise"},  t_run, 1);
    chk({tag, "_n_load"},    n_load, 1);
    chk({tag, "_n_clr"},     n_clr, 1);
    chk({tag, "_n_lfsr_en"}, n_len, 8);
    chk({tag, "_t_lfsr_en"}, t_len, 2);
    chk({tag, "_n_misr_en"}, n_men, 8);
    chk({tag, "_t_misr_en"}, t_men, sel ? 2 : 4);
    chk({tag, "_end_lat"},   t_end - t_run, sel ? 10 : 12);
    chk({tag, "_end_rises"}, n_rise, 1);
    chk({tag, "_overlap"},   n_both, 0);
    chk({tag, "_done_outs"}, o, {6'b000000, 1'b1, exp_pass});
  endtask

  initial begin
    logic [7:0] acc;
    // reset with start held high, then keep it high after release
    repeat (2) @(negedge clk);
    chk("rst_outs_a", oa, 8'h00);
    chk("rst_outs_z", oz, 8'h00);
    rst = 1'b0;
    acc = '0;
    repeat (20) begin
      @(negedge clk);
      acc = acc | oa | oz;
    end
    chk("held_start_no_run", acc, 8'h00);
    start_a = 1'b0;
    start_z = 1'b0;

    run(1'b0, 16'hBEEF, 1'b1, 0, 0, "pass");
    run(1'b0, 16'hBEEE, 1'b0, 0, 0, "fail");
    run(1'b0, 16'hBEEF, 1'b1, 0, 0, "repass");
    run(1'b0, 16'hBEEF, 1'b1, 4, 6, "retrig");

    // abort: rst sampled at the end of the 4th RUN cycle
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_lfsr_en", oa[6], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outs", oa, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_outs", oa, 8'h00);
    run(1'b0, 16'hBEEF, 1'b1, 0, 0, "post_rst");

    run(1'b1, 16'hBEEF, 1'b1, 0, 0, "lat0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/bist_ctrl.md
Name: bist_ctrl

Overview:
Sequencer for the BIST datapath. It drives the LFSR pattern generator, the test-mode input mux of the CUT and the MISR signature register, then compares the final MISR signature against a golden value. It sits between the top-level start/reset pins and the LFSR/CUT/MISR datapath inside `main`, and produces RUNNING, BIST_END and the pass flag.

Parameters:
N_PATTERNS, 1000, number of LFSR patterns applied per BIST run (≥1)
CNT_W, 10, pattern counter width; must satisfy 2^CNT_W ≥ N_PATTERNS
LAT, 1, CUT+capture pipeline latency in cycles (0..7) between lfsr_en and the corresponding misr_en
SIG_W, 16, MISR signature width
GOLDEN_SIG, 16'h0000, expected fault-free signature

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  BIST request; only a rising edge triggers a run
sig_in  in  SIG_W  current MISR contents
lfsr_load  out  1  load LFSR seed
lfsr_en  out  1  advance LFSR one pattern
misr_clr  out  1  clear MISR to its seed
misr_en  out  1  MISR compacts CUT response
test_mode  out  1  CUT input mux selects LFSR (1) or functional inputs (0)
running  out  1  BIST in progress
bist_end  out  1  run complete, bist_pass valid
bist_pass  out  1  1 = sig_in matched GOLDEN_SIG at check

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, counter 0, delay line 0, start_q=1, all outputs 0. rst has priority over every other input.
- start_q is registered start. A trigger is start & ~start_q. Because start_q resets to 1, a start held high through reset release does not trigger; a fresh rising edge is required.
- States: IDLE, INIT, RUN, FLUSH, CHECK, DONE.
- IDLE: outputs 0. Trigger → INIT.
- INIT (1 cycle): lfsr_load=1, misr_clr=1, test_mode=1, running=1, bist_pass cleared, counter cleared. Next state is RUN.
- RUN: lfsr_en=1, test_mode=1, running=1, counter increments each cycle. At counter==N_PATTERNS-1 the next state is FLUSH, or CHECK if LAT=0. RUN therefore lasts exactly N_PATTERNS cycles.
- misr_en: lfsr_en delayed by a LAT-stage shift register (combinational copy when LAT=0). It is high for exactly N_PATTERNS cycles.
- FLUSH: lfsr_en=0, test_mode=1, running=1. Lasts LAT cycles, counted by reusing the counter, then goes to CHECK.
- CHECK (1 cycle): running=1, test_mode=1. Registers bist_pass <= (sig_in == GOLDEN_SIG). The last misr_en pulse has already been captured. Next state is DONE.
- DONE: bist_end=1, running=0, test_mode=0, bist_pass held. A trigger goes to INIT, which clears bist_end and bist_pass. With no trigger, DONE holds indefinitely.
- Timing: running rises 1 cycle after the trigger is sampled. bist_end rises N_PATTERNS+LAT+2 cycles after running rises.
- Triggers in INIT/RUN/FLUSH/CHECK are ignored, and no retrigger is queued.
- rst mid-run aborts immediately to IDLE with all outputs 0. No partial result is reported.
- running and bist_end are never both 1.

Decomposition:
- bist_pkg holds the state enum (IDLE..DONE, 3-bit encoding) and the default GOLDEN_SIG/N_PATTERNS constants shared with the datapath and bench.
- Sub-module bist_pattern_cnt holds the CNT_W up-counter with clear, enable and terminal-count compare. It is used for both the RUN and FLUSH counts.

Test Plan:
(bench params: N_PATTERNS=8, LAT=2, SIG_W=16, GOLDEN_SIG=16'hBEEF)
1. rst high 2 cycles, then low with start=1 held for 20 cycles → no run; all outputs stay 0.
2. Single start pulse with sig_in=16'hBEEF → 1 cycle of lfsr_load/misr_clr; lfsr_en high 8 cycles; misr_en high 8 cycles starting 2 cycles later; bist_end rises 12 cycles after running rises; bist_pass=1.
3. Same run with sig_in=16'hBEEE → bist_end=1, bist_pass=0; rising start in DONE → INIT clears bist_end and bist_pass.
4. Start pulses on the 3rd and 5th RUN cycles → ignored; lfsr_en total stays 8 cycles and exactly one bist_end.
5. rst asserted on the 4th RUN cycle → next cycle all outputs 0, state IDLE; a later start runs a full 8-pattern test.
6. Rebuild with LAT=0 → misr_en coincides with lfsr_en, no FLUSH state, bist_end rises 10 cycles after running rises.
